// File: rtl/ulaw_pkg.sv
// Shared types and constants for the u-law serial transmit path.
package ulaw_pkg;
  localparam int ULAW_W     = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count. Pushes while full and
// pops while empty are ignored, so callers may assert them freely.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ulaw_serial_tx.sv
// Buffers u-law codes and sends each as an 11-bit async frame:
// start(0), d7..d0 MSB first, even parity, stop(1). tx_out is registered
// and computed from the next state so it changes exactly on bit edges.
module ulaw_serial_tx
  import ulaw_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ULAW_W-1:0] in_code,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              overflow
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t                 state, state_nxt;
  logic [CW-1:0]             bcnt, bcnt_nxt;
  logic [2:0]                dcnt, dcnt_nxt;
  logic [ULAW_W-1:0]         shreg, shreg_nxt;
  logic                      par, par_nxt;
  logic                      tx_nxt;
  logic                      bit_end;
  logic                      pop;
  logic                      fifo_full, fifo_empty;
  logic [ULAW_W-1:0]         fifo_code;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE) || (fifo_count != '0);

  sync_fifo #(
    .WIDTH (ULAW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data (in_code),
    .pop       (pop),
    .pop_data  (fifo_code),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state, counters, shift/parity load and the next line level.
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    dcnt_nxt  = dcnt;
    shreg_nxt = shreg;
    par_nxt   = par;
    pop       = 1'b0;
    bit_end   = (bcnt == BIT_LAST);
    tx_nxt    = 1'b1;

    if (state != IDLE) bcnt_nxt = bit_end ? '0 : bcnt + 1'b1;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
          shreg_nxt = fifo_code;
          par_nxt   = ^fifo_code;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          dcnt_nxt  = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (dcnt == 3'd7) begin
            state_nxt = PARITY;
          end else begin
            dcnt_nxt  = dcnt + 3'd1;
            shreg_nxt = {shreg[ULAW_W-2:0], 1'b0};
          end
        end
      end
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // back-to-back: next start bit begins on this edge
            pop       = 1'b1;
            state_nxt = START;
            shreg_nxt = fifo_code;
            par_nxt   = ^fifo_code;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[ULAW_W-1];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  // State, counters, data path and registered line output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bcnt   <= '0;
      dcnt   <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      tx_out <= 1'b1;
    end else begin
      state  <= state_nxt;
      bcnt   <= bcnt_nxt;
      dcnt   <= dcnt_nxt;
      shreg  <= shreg_nxt;
      par    <= par_nxt;
      tx_out <= tx_nxt;
    end
  end

  // One-cycle pulse for a code offered while the buffer is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= in_valid && fifo_full;
  end
endmodule

// File: tb/tb_ulaw_serial_tx.sv
// Directed bench for ulaw_serial_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on falling edges.
module tb_ulaw_serial_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FLEN  = ulaw_pkg::FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_code = 8'h00;
  logic       in_ready, tx_out, busy, overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [10:0] bits;
    int          st;
  } frame_t;
  frame_t frames[$];

  ulaw_serial_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (in_ready),
    .tx_out   (tx_out),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver: detects a start bit, samples each bit mid-period, and
  // discards any frame that saw reset.
  initial begin : rx
    frame_t f;
    bit     ab;
    forever begin
      @(negedge clk);
      if (rst_n && tx_out == 1'b0) begin
        f.st   = cyc;
        f.bits = '0;
        ab     = 1'b0;
        for (int c = 0; c < FLEN; c++) begin
          if (c > 0) @(negedge clk);
          if (!rst_n) ab = 1'b1;
          if (c % CPB == CPB / 2) f.bits = {f.bits[9:0], tx_out};
        end
        if (!ab) frames.push_back(f);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Expected frame from a code: start, data MSB first, even parity, stop.
  function automatic logic [10:0] frm(input logic [7:0] c);
    return {1'b0, c, ^c, 1'b1};
  endfunction

  task automatic wait_frame(input string tag, output frame_t f);
    int t = 0;
    while (frames.size() == 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " seen"}, (frames.size() != 0), 1);
    if (frames.size() != 0) f = frames.pop_front();
    else begin
      f.bits = '0;
      f.st   = 0;
    end
  endtask

  initial begin : main
    frame_t f, g, h;
    int lows;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst tx_out", tx_out, 1);
    chk("rst busy", busy, 0);
    chk("rst overflow", overflow, 0);
    chk("rst in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: single code 0xA5, latency and frame length
    frames.delete();
    in_valid = 1'b1; in_code = 8'hA5;
    @(negedge clk); in_valid = 1'b0;
    chk("t1 tx before pop", tx_out, 1);
    chk("t1 busy after push", busy, 1);
    @(negedge clk);
    chk("t1 start low", tx_out, 0);
    repeat (CPB - 1) @(negedge clk);
    chk("t1 start end low", tx_out, 0);
    @(negedge clk);
    chk("t1 d7", tx_out, 1);
    repeat (FLEN - 1 - CPB) @(negedge clk);
    chk("t1 busy last cycle", busy, 1);
    chk("t1 stop high", tx_out, 1);
    @(negedge clk);
    chk("t1 busy after frame", busy, 0);
    wait_frame("t1 frame", f);
    chk("t1 frame bits", f.bits, 11'b0_1010_0101_0_1);

    // T2: parity
    in_valid = 1'b1; in_code = 8'h80;
    @(negedge clk); in_valid = 1'b0;
    wait_frame("t2 frame 80", f);
    chk("t2 parity 80", f.bits[1], 1);
    chk("t2 frame 80", f.bits, 11'b0_1000_0000_1_1);
    repeat (3) @(negedge clk);
    in_valid = 1'b1; in_code = 8'hFF;
    @(negedge clk); in_valid = 1'b0;
    wait_frame("t2 frame ff", f);
    chk("t2 parity ff", f.bits[1], 0);
    chk("t2 frame ff", f.bits, 11'b0_1111_1111_0_1);
    repeat (3) @(negedge clk);
    chk("t2 idle", busy, 0);

    // T3: back-to-back frames
    in_valid = 1'b1; in_code = 8'h01;
    @(negedge clk); in_code = 8'h02;
    @(negedge clk); in_code = 8'h03;
    @(negedge clk); in_valid = 1'b0;
    wait_frame("t3 f1", f);
    wait_frame("t3 f2", g);
    wait_frame("t3 f3", h);
    chk("t3 f1 bits", f.bits, 11'b0_0000_0001_1_1);
    chk("t3 f2 bits", g.bits, 11'b0_0000_0010_1_1);
    chk("t3 f3 bits", h.bits, 11'b0_0000_0011_0_1);
    chk("t3 gap12", g.st - f.st, 44);
    chk("t3 gap23", h.st - g.st, 44);
    chk("t3 total", h.st + FLEN - f.st, 132);
    repeat (3) @(negedge clk);
    chk("t3 idle", busy, 0);

    // T4: overflow
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_code = 8'h10 + 8'(k);
      chk($sformatf("t4 in_ready %0d", k), in_ready, (k < 5) ? 1 : 0);
      chk($sformatf("t4 no ovf %0d", k), overflow, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t4 ovf pulse", overflow, 1);
    @(negedge clk);
    chk("t4 ovf single", overflow, 0);
    for (int k = 0; k < 5; k++) begin
      wait_frame($sformatf("t4 f%0d", k), f);
      chk($sformatf("t4 frame %0d", k), f.bits, frm(8'h10 + 8'(k)));
    end
    repeat (3) @(negedge clk);
    chk("t4 idle", busy, 0);
    chk("t4 no extra frame", frames.size(), 0);

    // T5: reset mid-frame with two codes queued
    frames.delete();
    in_valid = 1'b1; in_code = 8'h3C;
    @(negedge clk); in_code = 8'h40;
    @(negedge clk); in_code = 8'h41;
    @(negedge clk); in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5 mid data d6", tx_out, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 async tx", tx_out, 1);
    chk("t5 busy in rst", busy, 0);
    chk("t5 ready in rst", in_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5 busy after rst", busy, 0);
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx_out !== 1'b1) lows++;
    end
    chk("t5 line idle", lows, 0);
    chk("t5 no frame", frames.size(), 0);

    // T6: push on the STOP->START edge with one code queued
    frames.delete();
    in_valid = 1'b1; in_code = 8'h5A;
    @(negedge clk); in_code = 8'h33;
    @(negedge clk); in_valid = 1'b0;
    repeat (FLEN - 1) @(negedge clk);
    chk("t6 count before", dut.u_fifo.count, 1);
    chk("t6 in stop", tx_out, 1);
    in_valid = 1'b1; in_code = 8'hC3;
    @(negedge clk); in_valid = 1'b0;
    chk("t6 count after", dut.u_fifo.count, 1);
    chk("t6 next start", tx_out, 0);
    wait_frame("t6 f1", f);
    wait_frame("t6 f2", g);
    wait_frame("t6 f3", h);
    chk("t6 f1 bits", f.bits, frm(8'h5A));
    chk("t6 f2 bits", g.bits, frm(8'h33));
    chk("t6 f3 bits", h.bits, frm(8'hC3));
    chk("t6 gap12", g.st - f.st, 44);
    chk("t6 gap23", h.st - g.st, 44);
    repeat (3) @(negedge clk);
    chk("t6 idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
